// File: rtl/serializer_multilane_if.sv
`default_nettype none
// ============================================================================
// Module  : serializer_multilane_if
// Brief   : Parallel-side handshake and serial outputs of the multilane serializer.
// Revision: 1.0
// ============================================================================
interface serializer_multilane_if #(
  parameter int LANES = 2,
  parameter int WIDTH = 8
);
  logic [LANES*WIDTH-1:0] data_in;
  logic [LANES-1:0]       valid_in;
  logic [LANES-1:0]       ready_out;
  logic [LANES-1:0]       data_out;
  logic                   word_strobe;
  logic                   active_out;

  modport master (
    output data_in, valid_in,
    input  ready_out, data_out, word_strobe, active_out
  );

  modport slave (
    input  data_in, valid_in,
    output ready_out, data_out, word_strobe, active_out
  );
endinterface
`default_nettype wire

// File: rtl/serializer_multilane.sv
`default_nettype none
// ============================================================================
// Module  : serializer_multilane
// Brief   : LANES x WIDTH-bit parallel-to-serial transmitter, MSB first, shared
//           frame alignment, comma training after reset.
//           Optional macro SERIALIZER_PARITY_EN appends an even-parity bit.
// Revision: 1.0
// ============================================================================
module serializer_multilane #(
  parameter int               LANES       = 2,
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] IDLE_WORD   = WIDTH'(8'hBC),
  parameter int               TRAIN_WORDS = 4
) (
  input  wire logic             clk_8f,
  input  wire logic             reset,
  serializer_multilane_if.slave bus
);

`ifdef SERIALIZER_PARITY_EN
  localparam int FRAME = WIDTH + 1;
`else
  localparam int FRAME = WIDTH;
`endif
  localparam int               CNT_W        = $clog2(FRAME);
  localparam logic [CNT_W-1:0] C_CNT_LAST   = CNT_W'(FRAME - 1);
  localparam logic [7:0]       C_TRAIN_LAST = 8'(TRAIN_WORDS - 1);

  typedef enum logic [0:0] {
    S_TRAIN  = 1'b0,
    S_ACTIVE = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [7:0]       r_train_cnt;
  logic [7:0]       w_train_cnt_next;
  logic [CNT_W-1:0] r_cnt;
  logic             r_strobe;
  logic             r_active;
  logic             w_load;
  logic [LANES-1:0] w_ready;
  logic [LANES-1:0] w_data_out;

  assign w_load  = (r_cnt == C_CNT_LAST);
  assign w_ready = {LANES{(r_state == S_ACTIVE) && w_load}};

  // Reset parks the counter on the last slot so the first free cycle loads.
  always_ff @(posedge clk_8f) begin
    if (reset) begin
      r_cnt    <= C_CNT_LAST;
      r_strobe <= 1'b0;
    end else begin
      r_cnt    <= w_load ? '0 : r_cnt + 1'b1;
      r_strobe <= w_load;
    end
  end

  always_ff @(posedge clk_8f) begin
    if (reset) begin
      r_state     <= S_TRAIN;
      r_train_cnt <= 8'd0;
      r_active    <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_train_cnt <= w_train_cnt_next;
      r_active    <= (w_state_next == S_ACTIVE);
    end
  end

  always_comb begin
    w_state_next     = r_state;
    w_train_cnt_next = r_train_cnt;
    case (r_state)
      S_TRAIN: begin
        if (w_load) begin
          if (r_train_cnt == C_TRAIN_LAST) begin
            w_state_next = S_ACTIVE;
          end else begin
            w_train_cnt_next = r_train_cnt + 8'd1;
          end
        end
      end
      S_ACTIVE: w_state_next = S_ACTIVE;
      default:  w_state_next = S_TRAIN;
    endcase
  end

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic [WIDTH-1:0] w_word;
    logic [FRAME-1:0] w_frame;
    logic [FRAME-1:0] r_shift;
    logic             r_bit;

    assign w_word = (w_ready[gi] && bus.valid_in[gi]) ?
                    bus.data_in[gi*WIDTH +: WIDTH] : IDLE_WORD;
`ifdef SERIALIZER_PARITY_EN
    assign w_frame = {w_word, ^w_word};
`else
    assign w_frame = w_word;
`endif

    // The MSB leaves directly at the load edge; the rest follow from r_shift.
    always_ff @(posedge clk_8f) begin
      if (reset) begin
        r_shift <= '0;
        r_bit   <= 1'b0;
      end else if (w_load) begin
        r_bit   <= w_frame[FRAME-1];
        r_shift <= w_frame << 1;
      end else begin
        r_bit   <= r_shift[FRAME-1];
        r_shift <= r_shift << 1;
      end
    end

    assign w_data_out[gi] = r_bit;
  end

  assign bus.ready_out   = w_ready;
  assign bus.data_out    = w_data_out;
  assign bus.word_strobe = r_strobe;
  assign bus.active_out  = r_active;

endmodule
`default_nettype wire

// File: tb/tb_serializer_multilane.sv
`default_nettype none
// Bench for serializer_multilane: directed frame table, randomized traffic
// against a cycle-indexed reference model, and a mid-frame reset sequence.
module tb_serializer_multilane;
  localparam int LANES       = 2;
  localparam int WIDTH       = 8;
  localparam int TRAIN_WORDS = 4;
`ifdef SERIALIZER_PARITY_EN
  localparam int         F    = 9;
  localparam bit         PAR  = 1'b1;
  localparam logic [8:0] E_BC = 9'b101111001;
  localparam logic [8:0] E_A5 = 9'b101001010;
  localparam logic [8:0] E_3C = 9'b001111000;
  localparam logic [8:0] E_FF = 9'b111111110;
  localparam logic [8:0] E_01 = 9'b000000011;
  localparam logic [8:0] E_80 = 9'b100000001;
  localparam logic [8:0] E_07 = 9'b000001111;
`else
  localparam int         F    = 8;
  localparam bit         PAR  = 1'b0;
  localparam logic [8:0] E_BC = 9'h0BC;
  localparam logic [8:0] E_A5 = 9'h0A5;
  localparam logic [8:0] E_3C = 9'h03C;
  localparam logic [8:0] E_FF = 9'h0FF;
  localparam logic [8:0] E_01 = 9'h001;
  localparam logic [8:0] E_80 = 9'h080;
  localparam logic [8:0] E_07 = 9'h007;
`endif

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  serializer_multilane_if #(.LANES(LANES), .WIDTH(WIDTH)) bus ();

  serializer_multilane #(
    .LANES      (LANES),
    .WIDTH      (WIDTH),
    .IDLE_WORD  (8'hBC),
    .TRAIN_WORDS(TRAIN_WORDS)
  ) dut (
    .clk_8f(clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  typedef struct {
    logic [1:0] valid;
    logic [7:0] d0;
    logic [7:0] d1;
    logic [8:0] e0;
    logic [8:0] e1;
  } vec_t;

  vec_t       vecs[6];
  int         checks   = 0;
  int         failures = 0;
  int         t        = 0;
  logic [1:0] exp_q[$];
  logic [1:0] obs;
  logic [8:0] cap0 = '0;
  logic [8:0] cap1 = '0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0d actual=%h expected=%h", name, t, act, exp);
    end
  endtask

  task automatic apply(input logic [1:0] v, input logic [7:0] d0, input logic [7:0] d1);
    bus.valid_in = v;
    bus.data_in  = {d1, d0};
  endtask

  // Model: cycle t counts from reset release; frames load every F cycles from t=0,
  // and the first TRAIN_WORDS frames are forced commas.
  task automatic tick();
    logic [1:0] e_bits;
    logic [7:0] w;
    logic [8:0] fr0;
    logic [8:0] fr1;
    bit         load;
    int         k;
    @(negedge clk);
    load   = (t % F) == 0;
    k      = t / F;
    e_bits = 2'b00;
    if (exp_q.size() > 0) e_bits = exp_q.pop_front();
    obs = bus.data_out;
    chk("data_out", 16'(bus.data_out), 16'(e_bits));
    chk("ready_out", 16'(bus.ready_out), (load && k >= TRAIN_WORDS) ? 16'h3 : 16'h0);
    chk("word_strobe", 16'(bus.word_strobe), 16'((t % F) == 1));
    chk("active_out", 16'(bus.active_out), 16'(t > (TRAIN_WORDS - 1) * F));
    if (load) begin
      w   = (k >= TRAIN_WORDS && bus.valid_in[0]) ? bus.data_in[7:0] : 8'hBC;
      fr0 = PAR ? {w, ^w} : {1'b0, w};
      w   = (k >= TRAIN_WORDS && bus.valid_in[1]) ? bus.data_in[15:8] : 8'hBC;
      fr1 = PAR ? {w, ^w} : {1'b0, w};
      for (int n = 0; n < F; n++) exp_q.push_back({fr1[F-1-n], fr0[F-1-n]});
    end
    @(posedge clk);
    #1;
    t++;
  endtask

  task automatic capture();
    cap0 = {cap0[7:0], obs[0]};
    cap1 = {cap1[7:0], obs[1]};
  endtask

  initial begin
    int c;
    vecs[0] = '{2'b11, 8'h3C, 8'hA5, E_3C, E_A5};
    vecs[1] = '{2'b01, 8'hFF, 8'h77, E_FF, E_BC};
    vecs[2] = '{2'b11, 8'h01, 8'h01, E_01, E_01};
    vecs[3] = '{2'b11, 8'h80, 8'h80, E_80, E_80};
    vecs[4] = '{2'b10, 8'h12, 8'h07, E_BC, E_07};
    vecs[5] = '{2'b00, 8'h33, 8'h44, E_BC, E_BC};

    apply(2'b11, 8'h00, 8'h00);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_data_out", 16'(bus.data_out), 16'h0);
    chk("reset_ready_out", 16'(bus.ready_out), 16'h0);
    chk("reset_word_strobe", 16'(bus.word_strobe), 16'h0);
    chk("reset_active_out", 16'(bus.active_out), 16'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    t     = 0;

    // Training with valid_in held high: only commas may appear.
    while (t < TRAIN_WORDS * F) begin
      c = t;
      apply(2'b11, 8'($urandom), 8'($urandom));
      tick();
      capture();
      if (c > 0 && (c % F) == 0) begin
        chk("train_comma_l0", 16'(cap0[F-1:0]), 16'(E_BC[F-1:0]));
        chk("train_comma_l1", 16'(cap1[F-1:0]), 16'(E_BC[F-1:0]));
      end
    end

    // Directed frames on consecutive load cycles (gapless back-to-back).
    apply(vecs[0].valid, vecs[0].d0, vecs[0].d1);
    tick();
    for (int j = 0; j < 6; j++) begin
      for (int n = 1; n <= F; n++) begin
        if (n == F) begin
          if (j < 5) apply(vecs[j+1].valid, vecs[j+1].d0, vecs[j+1].d1);
          else       apply(2'b00, 8'h5A, 8'h5A);
        end
        tick();
        capture();
      end
      chk("vec_l0", 16'(cap0[F-1:0]), 16'(vecs[j].e0[F-1:0]));
      chk("vec_l1", 16'(cap1[F-1:0]), 16'(vecs[j].e1[F-1:0]));
    end

    repeat (200) begin
      apply(2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom));
      tick();
    end

    // Reset asserted while cnt == 3, then full retraining.
    while ((t % F) != 4) tick();
    reset = 1'b1;
    tick();
    chk("midreset_data_out", 16'(bus.data_out), 16'h0);
    chk("midreset_ready_out", 16'(bus.ready_out), 16'h0);
    chk("midreset_word_strobe", 16'(bus.word_strobe), 16'h0);
    chk("midreset_active_out", 16'(bus.active_out), 16'h0);
    reset = 1'b0;
    t     = 0;
    exp_q.delete();
    while (t < (TRAIN_WORDS + 3) * F) begin
      apply(2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom));
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
